// File: rtl/delay_window_monitor.sv
// Ranged-delay sequence monitor for "a ##[MIN_DELAY:MAX_DELAY] b".
// Tracks overlapping attempts by age; reports hits and (in CHECK mode) expiries.
module delay_window_monitor #(
    parameter int MIN_DELAY = 1,
    parameter int MAX_DELAY = 3,
    parameter int MODE      = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             a,
    input  logic             b,
    output logic             match,
    output logic             fail,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             busy
);

    if (MIN_DELAY < 1 || MAX_DELAY < MIN_DELAY || (MODE != 0 && MODE != 1)) begin : g_bad_params
        $error("delay_window_monitor: illegal MIN_DELAY/MAX_DELAY/MODE combination");
    end

    // pend[k] set: an attempt started k cycles ago is still open
    logic [MAX_DELAY:1] pend;
    logic [MAX_DELAY:1] pend_nxt;
    logic               hit;

    assign hit  = b && (|pend[MAX_DELAY:MIN_DELAY]);
    assign busy = |pend;

    // A hit retires every attempt inside the window; younger ones keep aging.
    always_comb begin
        pend_nxt = '0;
        if (!clear) begin
            pend_nxt[1] = a;
            for (int k = 2; k <= MAX_DELAY; k++)
                pend_nxt[k] = pend[k-1] && !(hit && (k - 1 >= MIN_DELAY));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend        <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            pend  <= pend_nxt;
            match <= hit;
            if (hit && match_count != {CNT_W{1'b1}})
                match_count <= match_count + 1'b1;
        end
    end

    if (MODE == 1) begin : g_check
        logic expire;

        // b on the last open cycle is a hit, so expiry and hit never coincide
        assign expire = pend[MAX_DELAY] && !b;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                fail       <= 1'b0;
                fail_count <= '0;
            end else begin
                fail <= expire;
                if (expire && fail_count != {CNT_W{1'b1}})
                    fail_count <= fail_count + 1'b1;
            end
        end
    end else begin : g_cover
        assign fail       = 1'b0;
        assign fail_count = '0;
    end

endmodule

// File: tb/tb_delay_window_monitor.sv
// Bench for delay_window_monitor: four parameterisations share one stimulus stream,
// each checked every cycle against an attempt-age queue model, plus directed literal checks.
module tb_delay_window_monitor;

    localparam int N = 4;
    localparam int MN [N] = '{1, 1, 1, 2};
    localparam int MX [N] = '{3, 3, 3, 5};
    localparam int CK [N] = '{1, 0, 1, 1};
    localparam int CW [N] = '{16, 16, 2, 16};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;

    logic [N-1:0]       m, f, bz;
    logic [N-1:0][15:0] mc, fc;
    logic [1:0]         mc2, fc2;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    delay_window_monitor #(.MIN_DELAY(1), .MAX_DELAY(3), .MODE(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .clear(clear), .a(a), .b(b), .match(m[0]), .fail(f[0]),
        .match_count(mc[0]), .fail_count(fc[0]), .busy(bz[0]));
    delay_window_monitor #(.MIN_DELAY(1), .MAX_DELAY(3), .MODE(0), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .clear(clear), .a(a), .b(b), .match(m[1]), .fail(f[1]),
        .match_count(mc[1]), .fail_count(fc[1]), .busy(bz[1]));
    delay_window_monitor #(.MIN_DELAY(1), .MAX_DELAY(3), .MODE(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .clear(clear), .a(a), .b(b), .match(m[2]), .fail(f[2]),
        .match_count(mc2), .fail_count(fc2), .busy(bz[2]));
    delay_window_monitor #(.MIN_DELAY(2), .MAX_DELAY(5), .MODE(1), .CNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .clear(clear), .a(a), .b(b), .match(m[3]), .fail(f[3]),
        .match_count(mc[3]), .fail_count(fc[3]), .busy(bz[3]));

    assign mc[2] = {14'd0, mc2};
    assign fc[2] = {14'd0, fc2};

    task automatic cmp(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each open attempt is just its age in a queue.
    int q [N][$];
    int nq [$];
    bit h, e;
    bit [N-1:0] em, ef, eb;
    int emc [N];
    int efc [N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                q[i].delete();
                em[i] = 0; ef[i] = 0; eb[i] = 0; emc[i] = 0; efc[i] = 0;
            end else begin
                h = 0; e = 0;
                nq.delete();
                for (int j = 0; j < q[i].size(); j++) begin
                    if (b && q[i][j] >= MN[i] && q[i][j] <= MX[i]) h = 1;
                    if (CK[i] != 0 && !b && q[i][j] == MX[i]) e = 1;
                end
                if (!clear) begin
                    for (int j = 0; j < q[i].size(); j++)
                        if (q[i][j] < MX[i] && !(h && q[i][j] >= MN[i]))
                            nq.push_back(q[i][j] + 1);
                    if (a) nq.push_back(1);
                end
                q[i] = nq;
                em[i] = h;
                ef[i] = e;
                eb[i] = (q[i].size() != 0);
                if (h && emc[i] < (1 << CW[i]) - 1) emc[i]++;
                if (e && efc[i] < (1 << CW[i]) - 1) efc[i]++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < N; i++) begin
                cmp($sformatf("match%0d", i), int'(m[i]), int'(em[i]));
                cmp($sformatf("fail%0d", i), int'(f[i]), int'(ef[i]));
                cmp($sformatf("busy%0d", i), int'(bz[i]), int'(eb[i]));
                cmp($sformatf("match_count%0d", i), int'(mc[i]), emc[i]);
                cmp($sformatf("fail_count%0d", i), int'(fc[i]), efc[i]);
            end
        end
    end

    task automatic step(input bit ai, input bit bi, input bit ci);
        a = ai; b = bi; clear = ci;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        a = 0; b = 0; clear = 0;
        rst = 1;
        #1;
        cmp("reset_busy", int'(bz[0]), 0);
        cmp("reset_match_count", int'(mc[0]), 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        rst = 0;
        chk_on = 1;
        cmp("init_match", int'(m[0]), 0);
        cmp("init_fail", int'(f[0]), 0);

        // basic hit: a@0, b@2
        step(1, 0, 0);
        step(0, 0, 0);
        cmp("basic_busy_open", int'(bz[0]), 1);
        step(0, 1, 0);
        cmp("basic_match", int'(m[0]), 1);
        cmp("basic_match_count", int'(mc[0]), 1);
        cmp("basic_busy_done", int'(bz[0]), 0);
        step(0, 0, 0);
        cmp("basic_match_once", int'(m[0]), 0);

        // expiry: a@0, b@5
        do_reset();
        step(1, 0, 0);
        repeat (2) step(0, 0, 0);
        cmp("exp_no_fail_early", int'(f[0]), 0);
        step(0, 0, 0);
        cmp("exp_fail", int'(f[0]), 1);
        cmp("exp_fail_count", int'(fc[0]), 1);
        cmp("exp_cover_fail", int'(f[1]), 0);
        step(0, 0, 0);
        step(0, 1, 0);
        cmp("exp_no_match", int'(mc[0]), 0);
        cmp("exp_cover_fcount", int'(fc[1]), 0);
        cmp("exp_cover_mcount", int'(mc[1]), 0);

        // overlapping: a@0,1, b@2
        do_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        cmp("ovl_match", int'(m[0]), 1);
        repeat (4) step(0, 0, 0);
        cmp("ovl_match_count", int'(mc[0]), 1);
        cmp("ovl_no_fail", int'(fc[0]), 0);

        // out-of-window events
        do_reset();
        step(0, 1, 0);
        cmp("oow_b_only", int'(m[0]), 0);
        step(1, 1, 0);
        cmp("oow_same_cycle", int'(m[0]), 0);
        step(0, 1, 0);
        cmp("oow_next_b", int'(m[0]), 1);

        // saturation on the 2-bit instance
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            step(1, 0, 0);
            step(0, 1, 0);
            cmp($sformatf("sat_count_%0d", n), int'(mc2), (n < 3) ? n : 3);
        end

        // reset mid-attempt
        do_reset();
        step(1, 0, 0);
        rst = 1;
        #1;
        cmp("rst_busy_async", int'(bz[0]), 0);
        step(0, 0, 0);
        rst = 0;
        step(0, 1, 0);
        cmp("rst_no_match", int'(m[0]), 0);
        repeat (3) step(0, 0, 0);
        cmp("rst_no_fail", int'(fc[0]), 0);
        cmp("rst_mcount", int'(mc[0]), 0);

        // clear with simultaneous a
        do_reset();
        step(1, 0, 0);
        step(1, 0, 1);
        cmp("clr_busy", int'(bz[0]), 0);
        repeat (4) step(0, 0, 0);
        cmp("clr_no_fail", int'(fc[0]), 0);

        // random
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(255) == 0) begin
                rst = 1;
                step(0, 0, 0);
                rst = 0;
            end else begin
                step($urandom_range(1) == 1, $urandom_range(2) == 0, $urandom_range(31) == 0);
            end
        end

        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
